// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : seven_seg_scan_ctrl
// Description : Multiplexed common-anode seven-segment scanner. Time-slices
//               NUM_DIGITS digits with a slot prescaler, blanks the start of
//               each slot against ghosting, skips masked digits and pulses
//               frame_done when the scan wraps. All outputs are registered.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 100000,
   parameter int BLANK_CYCLES = 1000,
   localparam int SW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [7*NUM_DIGITS-1:0] seg_data,
   input  logic [NUM_DIGITS-1:0]   dp_data,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [SW-1:0]           digit_sel,
   output logic                    frame_done
);

   localparam int             CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0]  c_last_cnt = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0]  c_blank    = CW'(BLANK_CYCLES);

   localparam logic [0:0]     c_st_idle  = 1'b0;
   localparam logic [0:0]     c_st_scan  = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [SW-1:0]         sel_q, sel_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic                  fd_q, fd_d;

   logic                  any_en;
   logic [SW-1:0]         first_sel;
   logic [SW-1:0]         next_sel;
   logic                  found;

   assign any_en = |digit_en;

   // Lowest enabled digit, used when scanning starts from idle
   always_comb begin
      first_sel = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (digit_en[i]) first_sel = SW'(i);
      end
   end

   // First enabled digit strictly after the current one, searching circularly;
   // the current digit itself is reached last, so a lone digit re-selects
   always_comb begin
      next_sel = sel_q;
      found    = 1'b0;
      for (int k = 1; k <= NUM_DIGITS; k++) begin
         for (int j = 0; j < NUM_DIGITS; j++) begin
            if (!found && (j == (int'(sel_q) + k) % NUM_DIGITS) && digit_en[j]) begin
               next_sel = SW'(j);
               found    = 1'b1;
            end
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= c_st_idle;
      else        state_q <= state_d;
   end

   // Next-state: scan while enabled with at least one digit unmasked
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_st_idle: if (enable && any_en)    state_d = c_st_scan;
         c_st_scan: if (!enable || !any_en)  state_d = c_st_idle;
         default:                            state_d = c_st_idle;
      endcase
   end

   // Output/next-slot decode; leaving SCAN falls through to the reset values
   always_comb begin
      cnt_d   = '0;
      sel_d   = '0;
      fd_d    = 1'b0;
      anode_d = '1;
      seg_d   = 7'h7F;
      dp_d    = 1'b1;
      if (state_d == c_st_scan) begin
         if (state_q == c_st_idle) begin
            sel_d = first_sel;
         end else if (cnt_q == c_last_cnt) begin
            sel_d = next_sel;
            fd_d  = (next_sel <= sel_q);
         end else begin
            cnt_d = cnt_q + CW'(1);
            sel_d = sel_q;
         end
         if (cnt_d >= c_blank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (sel_d == SW'(i)) begin
                  anode_d[i] = ~digit_en[i];
                  seg_d      = ~seg_data[7*i +: 7];
                  dp_d       = ~dp_data[i];
               end
            end
         end
      end
   end

   // Slot counter and registered display outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         sel_q   <= '0;
         anode_q <= '1;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         fd_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         anode_q <= anode_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         fd_q    <= fd_d;
      end
   end

   assign anode      = anode_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign digit_sel  = sel_q;
   assign frame_done = fd_q;

endmodule
`default_nettype wire
